et_adder_vl: RTL and testbench
==============================

Name: et_adder_vl

Overview:
- Parametrised, variable-latency error-tolerant adder; next generation of the fixed 32-bit combinational ET adder.
- Splits operands into BLK-bit blocks. Each block carry-in is speculated from a LOOK-bit window below it.
- Runtime mode selects one of two behaviours: approximate (speculative result, error flagged) or exact (one extra correction cycle on misprediction).
- Sits in datapaths behind a valid/ready handshake. Operands are registered at accept.

Parameters:
- WIDTH, 32, operand width; must be a multiple of BLK.
- BLK, 4, block width in bits.
- LOOK, 4, carry-speculation window in bits; 1..WIDTH.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  operand accept
- add1_i  in  WIDTH  operand A
- add2_i  in  WIDTH  operand B
- mode_i  in  1  0 = approximate, 1 = exact; sampled at accept
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result accept
- result_o  out  WIDTH+1  sum, MSB = carry out
- err_o  out  1  at least one block carry was mispredicted

Behaviour:
- Clocking: one clock; reset is synchronous and active-low on rst_ni.
- Speculation rule:
  - Block 0 carry-in = 0.
  - Block k≥1 predicted carry-in = carry out of adding A and B over bits [kBLK-LOOK, kBLK-1] with carry-in 0. Window is clipped at bit 0.
  - Each block sum = A_blk + B_blk + predicted carry.
  - result_o[WIDTH] = carry out of the top block.
  - miss = OR over all blocks of (predicted carry != true ripple carry).
- States:
  - IDLE: in_ready_o=1. On in_valid_i, latch add1_i, add2_i, mode_i; go to SPEC.
  - SPEC (1 cycle): if mode=0 or miss=0, register result_o=speculative sum, err_o=miss, go to HOLD. Otherwise go to FIX.
  - FIX (1 cycle): register result_o=exact A+B, err_o=1, go to HOLD.
  - HOLD: out_valid_o=1. On out_ready_i, go to IDLE. If in_valid_i is also high, accept the new operands in the same cycle and go directly to SPEC.
- in_ready_o = (state==IDLE) | (state==HOLD & out_ready_i). This is a combinational path from out_ready_i.
- Latency, counted from the accept edge to out_valid_o high:
  - 2 cycles, normal case.
  - 3 cycles, exact mode with a miss.
- Throughput: one result per 2 cycles, best case.
- Result stability: result_o and err_o are stable throughout HOLD and change only when a new result is registered.
- Exactness: when LOOK ≥ WIDTH-BLK, miss is always 0 and the result is always exact.
- Reset values: state=IDLE, out_valid_o=0, result_o=0, err_o=0. in_ready_o=0 while rst_ni=0.
- Reset mid-operation (SPEC, FIX or HOLD): the in-flight transaction is discarded and no output is produced for it.
- Handshake outside IDLE/HOLD: in_valid_i has no effect.

Optional Feature:
- Macro: ET_ADDER_STATS_EN.
- When defined, add outputs ops_cnt_o (32) and miss_cnt_o (32):
  - ops_cnt_o counts results delivered (out_valid_o & out_ready_i).
  - miss_cnt_o counts delivered results with err_o=1.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Decomposition:
- Package et_adder_pkg:
  - state enum {IDLE, SPEC, FIX, HOLD}
  - MODE_APPROX=1'b0, MODE_EXACT=1'b1
  - elaboration check function for WIDTH%BLK==0 and 1≤LOOK≤WIDTH
- Sub-module et_spec_adder (combinational, same parameters): inputs A and B; outputs speculative sum (WIDTH+1), exact sum (WIDTH+1), miss.
- The top level holds the FSM, registers, handshake and optional counters.

Test Plan (WIDTH=32, BLK=4, LOOK=4):
- Approximate miss: A=0x000000FF, B=0x00000001, mode=0 -> result_o=0x000000000, err_o=1, out_valid_o 2 cycles after accept.
- Exact correction: same operands, mode=1 -> result_o=0x000000100, err_o=1, out_valid_o 3 cycles after accept.
- No miss: A=0x12345678, B=0x11111111, in both modes -> result_o=0x023456789, err_o=0, latency 2.
- Overflow: A=B=0xFFFFFFFF, mode=0 -> result_o=0x1FFFFFFFE, err_o=0.
- Backpressure:
  - Hold out_ready_i=0 for 5 cycles in HOLD -> result_o stable, in_ready_o=0.
  - Then raise out_ready_i with in_valid_i=1 -> new operands accepted in the same cycle, next result 2 cycles later.
- Reset during FIX:
  - rst_ni=0 for one cycle -> out_valid_o=0, result_o=0, err_o=0, and that transaction never appears.
  - With ET_ADDER_STATS_EN, after the two delivered results from the first two scenarios -> ops_cnt_o=2, miss_cnt_o=2.

Source files
------------

// File: rtl/et_adder_pkg.sv
// rtl/et_adder_pkg.sv - shared types, mode encodings and parameter check for the ET adder
package et_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPEC = 2'd1,
    FIX  = 2'd2,
    HOLD = 2'd3
  } et_state_e;

  localparam logic MODE_APPROX = 1'b0;
  localparam logic MODE_EXACT  = 1'b1;

  function automatic bit et_params_ok(input int width, input int blk, input int look);
    return (blk > 0) && (width >= blk) && ((width % blk) == 0) && (look >= 1) && (look <= width);
  endfunction

endpackage

// File: rtl/et_spec_adder.sv
// rtl/et_spec_adder.sv - combinational block-speculative adder with exact sum and miss flag
module et_spec_adder
  import et_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLK   = 4,
  parameter int LOOK  = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   spec_sum_o,
  output logic [WIDTH:0]   exact_sum_o,
  output logic             miss_o
);

  localparam int NBLK = WIDTH / BLK;

  logic [NBLK-1:0] pred_c;
  logic [NBLK-1:0] true_c;

  assign exact_sum_o = {1'b0, a_i} + {1'b0, b_i};

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    if (k == 0) begin : g_base
      assign pred_c[k] = 1'b0;
      assign true_c[k] = 1'b0;
    end else begin : g_pred
      localparam int HI = k * BLK;
      localparam int LO = (HI > LOOK) ? HI - LOOK : 0;
      // x + y overflows its width exactly when y > ~x
      assign pred_c[k] = (b_i[HI-1:LO] > ~a_i[HI-1:LO]);
      assign true_c[k] = exact_sum_o[HI] ^ a_i[HI] ^ b_i[HI];
    end

    if (k == NBLK - 1) begin : g_top
      assign spec_sum_o[WIDTH:k*BLK] = {1'b0, a_i[k*BLK +: BLK]} + {1'b0, b_i[k*BLK +: BLK]}
                                     + {{BLK{1'b0}}, pred_c[k]};
    end else begin : g_mid
      assign spec_sum_o[k*BLK +: BLK] = a_i[k*BLK +: BLK] + b_i[k*BLK +: BLK]
                                      + {{(BLK-1){1'b0}}, pred_c[k]};
    end
  end

  assign miss_o = |(pred_c ^ true_c);

endmodule

// File: rtl/et_adder_vl.sv
// rtl/et_adder_vl.sv - variable-latency ET adder top: FSM, operand/result registers, handshake
// Optional ET_ADDER_STATS_EN adds saturating delivered-result and miss counters.
module et_adder_vl
  import et_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLK   = 4,
  parameter int LOOK  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   result_o,
`ifdef ET_ADDER_STATS_EN
  output logic [31:0]      ops_cnt_o,
  output logic [31:0]      miss_cnt_o,
`endif
  output logic             err_o
);

  if (!et_params_ok(WIDTH, BLK, LOOK)) begin : g_bad_params
    $error("et_adder_vl: WIDTH must be a multiple of BLK and LOOK must be in 1..WIDTH");
  end

  et_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   spec_sum;
  logic [WIDTH:0]   exact_sum;
  logic             miss;
  logic             accept;

  et_spec_adder #(
    .WIDTH (WIDTH),
    .BLK   (BLK),
    .LOOK  (LOOK)
  ) u_spec (
    .a_i         (a_q),
    .b_i         (b_q),
    .spec_sum_o  (spec_sum),
    .exact_sum_o (exact_sum),
    .miss_o      (miss)
  );

  assign in_ready_o  = rst_ni & ((state_q == IDLE) | ((state_q == HOLD) & out_ready_i));
  assign accept      = in_ready_o & in_valid_i;
  assign out_valid_o = (state_q == HOLD);
  assign result_o    = result_q;
  assign err_o       = err_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    result_d = result_q;
    err_d    = err_q;

    if (accept) begin
      a_d    = add1_i;
      b_d    = add2_i;
      mode_d = mode_i;
    end

    case (state_q)
      IDLE: if (in_valid_i) state_d = SPEC;
      SPEC: begin
        if (mode_q == MODE_EXACT && miss) begin
          state_d = FIX;
        end else begin
          result_d = spec_sum;
          err_d    = miss;
          state_d  = HOLD;
        end
      end
      FIX: begin
        result_d = exact_sum;
        err_d    = 1'b1;
        state_d  = HOLD;
      end
      HOLD: if (out_ready_i) state_d = in_valid_i ? SPEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= MODE_APPROX;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

`ifdef ET_ADDER_STATS_EN
  logic [31:0] ops_cnt_q, ops_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        deliver;

  assign deliver = out_valid_o & out_ready_i;

  always_comb begin
    ops_cnt_d  = ops_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (deliver && ops_cnt_q != 32'hFFFF_FFFF) ops_cnt_d = ops_cnt_q + 32'd1;
    if (deliver && err_q && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ops_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      ops_cnt_q  <= ops_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign ops_cnt_o  = ops_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_et_adder_vl.sv
// tb/tb_et_adder_vl.sv - self-checking bench: vector table, corner sequences, random ops vs model
module tb_et_adder_vl;

  localparam int WIDTH = 32;
  localparam int BLK   = 4;
  localparam int LOOK  = 4;
  localparam int NBLK  = WIDTH / BLK;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] add1;
  logic [WIDTH-1:0] add2;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             err;
`ifdef ET_ADDER_STATS_EN
  logic [31:0]      ops_cnt;
  logic [31:0]      miss_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  et_adder_vl #(.WIDTH(WIDTH), .BLK(BLK), .LOOK(LOOK)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .add1_i      (add1),
    .add2_i      (add2),
    .mode_i      (mode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
`ifdef ET_ADDER_STATS_EN
    .ops_cnt_o   (ops_cnt),
    .miss_cnt_o  (miss_cnt),
`endif
    .err_o       (err)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic [WIDTH:0]   res;
    logic             e;
    int               lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: per-block arithmetic straight from the speculation rules
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic m, output logic [WIDTH:0] res,
                                output logic e, output int lat);
    longint unsigned sa = 64'(a);
    longint unsigned sb = 64'(b);
    longint unsigned spec = 0;
    longint unsigned blk_sum;
    longint unsigned mask;
    longint unsigned pc;
    longint unsigned tc;
    bit miss = 0;
    for (int k = 0; k < NBLK; k++) begin
      int hi = k * BLK;
      int lo = (hi > LOOK) ? hi - LOOK : 0;
      if (k == 0) begin
        pc = 0;
        tc = 0;
      end else begin
        mask = (64'd1 << (hi - lo)) - 1;
        pc   = (((sa >> lo) & mask) + ((sb >> lo) & mask)) >> (hi - lo);
        mask = (64'd1 << hi) - 1;
        tc   = ((sa & mask) + (sb & mask)) >> hi;
      end
      if (pc != tc) miss = 1;
      blk_sum = ((sa >> hi) & ((64'd1 << BLK) - 1)) + ((sb >> hi) & ((64'd1 << BLK) - 1)) + pc;
      spec |= (blk_sum & ((64'd1 << BLK) - 1)) << hi;
      if (k == NBLK - 1) spec |= (blk_sum >> BLK) << WIDTH;
    end
    if (m && miss) begin
      res = (WIDTH+1)'(sa + sb);
      e   = 1'b1;
      lat = 3;
    end else begin
      res = (WIDTH+1)'(spec);
      e   = miss;
      lat = 2;
    end
  endfunction

  task automatic do_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic m, input logic [WIDTH:0] er, input logic ee, input int el,
                       input int hold_cycles);
    int lat;
    int wt = 0;
    @(negedge clk);
    while (!in_ready && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    add1 = a; add2 = b; mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, 64'(lat), 64'(el));
    chk({name, "_res"}, 64'(result), 64'(er));
    chk({name, "_err"}, 64'(err), 64'(ee));
    repeat (hold_cycles) begin
      @(posedge clk); #1;
      chk({name, "_hold_res"}, 64'(result), 64'(er));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    logic [WIDTH:0] er;
    logic           ee;
    int             el;
    logic [WIDTH-1:0] ra, rb;
    logic           rm;
    bit             seen;

    vecs.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0000, 1'b1, 2});
    vecs.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b1, 33'h0_0000_0100, 1'b1, 3});
    vecs.push_back('{32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789, 1'b0, 2});
    vecs.push_back('{32'h1234_5678, 32'h1111_1111, 1'b1, 33'h0_2345_6789, 1'b0, 2});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33'h1_FFFF_FFFE, 1'b0, 2});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0_0000_0000, 1'b0, 2});
    vecs.push_back('{32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_0FFF_FF00, 1'b1, 2});
    vecs.push_back('{32'h0FFF_FFFF, 32'h0000_0001, 1'b1, 33'h0_1000_0000, 1'b1, 3});

    rst_ni = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    add1 = '0; add2 = '0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].m,
            vecs[i].res, vecs[i].e, vecs[i].lat, 0);
`ifdef ET_ADDER_STATS_EN
      if (i == 1) begin
        chk("stats_ops_after_two", 64'(ops_cnt), 64'd2);
        chk("stats_miss_after_two", 64'(miss_cnt), 64'd2);
      end
`endif
    end

    // Backpressure: result held for 5 cycles, then back-to-back accept
    @(negedge clk);
    add1 = 32'h1234_5678; add2 = 32'h1111_1111; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_valid", 64'(out_valid), 64'd1);
    repeat (5) begin
      @(negedge clk); #1;
      chk("bp_stable_res", 64'(result), 64'h0_2345_6789);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    add1 = 32'h0000_0001; add2 = 32'h0000_0002; mode = 1'b0;
    #1;
    chk("bp_in_ready_comb", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_spec_not_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("bp_next_valid", 64'(out_valid), 64'd1);
    chk("bp_next_res", 64'(result), 64'h3);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset while in FIX: transaction dropped
    @(negedge clk);
    add1 = 32'h0000_00FF; add2 = 32'h0000_0001; mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("fix_not_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    chk("rst_fix_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rst_fix_valid", 64'(out_valid), 64'd0);
    chk("rst_fix_result", 64'(result), 64'd0);
    chk("rst_fix_err", 64'(err), 64'd0);
`ifdef ET_ADDER_STATS_EN
    chk("rst_fix_ops_cnt", 64'(ops_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_ni = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("rst_fix_dropped", 64'(seen), 64'd0);
    chk("rst_fix_idle", 64'(in_ready), 64'd1);

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) begin
        ra = ra | 32'h0000_FFF0;
        rb = rb | 32'h0000_0001;
      end
      rm = 1'($urandom_range(0, 1));
      model(ra, rb, rm, er, ee, el);
      do_op($sformatf("rnd%0d", i), ra, rb, rm, er, ee, el, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
